// File: rtl/purge_monitor.sv
// Supervisor for the self-purging adder array: re-arms the module switches,
// logs purge events and declares failure when too few modules remain.
module purge_monitor #(
    parameter int unsigned N       = 6,
    parameter int unsigned THR     = 4,
    parameter int unsigned ARM_CYC = 2,
    parameter int unsigned CW      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       clr,
    input  logic [N-1:0]               active,
    output logic                       arm_o,
    output logic [1:0]                 state_o,
    output logic [$clog2(N+1)-1:0]     active_cnt,
    output logic                       purge_evt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] purge_id,
    output logic [N-1:0]               purge_mask,
    output logic [CW-1:0]              purge_total,
    output logic                       degraded,
    output logic                       fail,
    output logic                       reenable_err
);

    localparam int unsigned CNTW = $clog2(N + 1);
    localparam int unsigned IDW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ACW  = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
    localparam int unsigned SW   = ((CW > CNTW) ? CW : CNTW) + 1;
    localparam logic [CW-1:0] TOTAL_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ACW-1:0]    arm_cnt_q, arm_cnt_d;
    logic [N-1:0]      active_q;
    logic              arm_q, arm_d;
    logic [CNTW-1:0]   cnt_q;
    logic              evt_q, evt_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [N-1:0]      mask_q, mask_d;
    logic [CW-1:0]     total_q, total_d;
    logic              degraded_q, degraded_d;
    logic              fail_q, fail_d;
    logic              ren_q, ren_d;

    logic [N-1:0]      fall, rise;
    logic [CNTW-1:0]   act_cnt, fall_cnt;
    logic [SW-1:0]     total_sum;
    logic              log_fall;

    function automatic logic [CNTW-1:0] popcount(input logic [N-1:0] v);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(N); i++) c = c + CNTW'(v[i]);
        return c;
    endfunction

    function automatic logic [IDW-1:0] lowest_idx(input logic [N-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) if (v[i]) idx = IDW'(i);
        return idx;
    endfunction

    // Next-state, event logging and history update
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        arm_d     = 1'b0;
        evt_d     = 1'b0;
        id_d      = id_q;
        mask_d    = mask_q;
        total_d   = total_q;
        ren_d     = ren_q;
        log_fall  = 1'b0;

        fall      = active_q & ~active;
        rise      = ~active_q & active;
        act_cnt   = popcount(active);
        fall_cnt  = popcount(fall);
        total_sum = SW'(total_q) + SW'(fall_cnt);

        if (clr) begin
            state_d   = S_IDLE;
            arm_cnt_d = '0;
            id_d      = '0;
            mask_d    = '0;
            total_d   = '0;
            ren_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_ARM;
                        arm_d     = 1'b1;
                        arm_cnt_d = ACW'(ARM_CYC - 1);
                    end
                end
                S_ARM: begin
                    if (arm_cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        arm_cnt_d = arm_cnt_q - 1'b1;
                        arm_d     = 1'b1;
                    end
                end
                S_RUN: begin
                    log_fall = 1'b1;
                    if (|(rise & mask_q)) ren_d = 1'b1;
                    if (act_cnt < CNTW'(THR)) state_d = S_FAIL;
                end
                S_FAIL: begin
                    log_fall = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase

            if (log_fall && (|fall)) begin
                evt_d   = 1'b1;
                id_d    = lowest_idx(fall);
                mask_d  = mask_q | fall;
                total_d = (total_sum > SW'(TOTAL_MAX)) ? TOTAL_MAX : total_sum[CW-1:0];
            end
        end

        fail_d     = (state_d == S_FAIL);
        degraded_d = ((state_d == S_RUN) || (state_d == S_FAIL)) && (act_cnt < CNTW'(N));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            arm_cnt_q  <= '0;
            active_q   <= '0;
            arm_q      <= 1'b0;
            cnt_q      <= '0;
            evt_q      <= 1'b0;
            id_q       <= '0;
            mask_q     <= '0;
            total_q    <= '0;
            degraded_q <= 1'b0;
            fail_q     <= 1'b0;
            ren_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            active_q   <= active;
            arm_q      <= arm_d;
            cnt_q      <= act_cnt;
            evt_q      <= evt_d;
            id_q       <= id_d;
            mask_q     <= mask_d;
            total_q    <= total_d;
            degraded_q <= degraded_d;
            fail_q     <= fail_d;
            ren_q      <= ren_d;
        end
    end

    assign arm_o        = arm_q;
    assign state_o      = state_q;
    assign active_cnt   = cnt_q;
    assign purge_evt    = evt_q;
    assign purge_id     = id_q;
    assign purge_mask   = mask_q;
    assign purge_total  = total_q;
    assign degraded     = degraded_q;
    assign fail         = fail_q;
    assign reenable_err = ren_q;

endmodule
